// File: rtl/fm_period_demod.sv
// Period demodulator for an offset-binary sine carrier: hysteretic rising-crossing
// detection, accepted-sample counting across 2**AVG_LOG2 periods, and loss-of-signal.
module fm_period_demod #(
   parameter int SINE_WIDTH  = 7,
   parameter int HYST        = 4,
   parameter int AVG_LOG2    = 4,
   parameter int COUNT_WIDTH = 16,
   parameter int TIMEOUT     = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   sample_valid,
   input  logic [SINE_WIDTH-1:0]  sample,
   output logic [COUNT_WIDTH-1:0] period_sum,
   output logic                   period_valid,
   output logic                   signal_lost,
   output logic                   crossing
);

   localparam int MID  = 2 ** (SINE_WIDTH - 1);
   localparam int NWIN = 2 ** AVG_LOG2;

   localparam logic signed [SINE_WIDTH:0] MID_S      = MID;
   localparam logic signed [SINE_WIDTH:0] HYST_S     = HYST;
   localparam logic signed [SINE_WIDTH:0] NEG_HYST_S = -HYST;
   localparam logic [COUNT_WIDTH-1:0]     TIMEOUT_C  = COUNT_WIDTH'(TIMEOUT);
   localparam logic [AVG_LOG2:0]          NWIN_C     = (AVG_LOG2 + 1)'(NWIN);

   // A hysteresis band reaching the rails would make every crossing unreachable.
   if (HYST >= MID - 1) begin : g_bad_hyst
      $error("fm_period_demod: HYST must be below 2**(SINE_WIDTH-1)-1");
   end
   if (longint'(TIMEOUT) >= (longint'(1) << COUNT_WIDTH)) begin : g_bad_timeout
      $error("fm_period_demod: TIMEOUT must fit in COUNT_WIDTH bits");
   end

   typedef enum logic {
      SEEK    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   state_t                   r_state;
   logic                     r_armed;
   logic [COUNT_WIDTH-1:0]   r_count;
   logic [AVG_LOG2:0]        r_ncross;
   logic [COUNT_WIDTH-1:0]   r_period_sum;
   logic                     r_period_valid;
   logic                     r_signal_lost;
   logic                     r_crossing;

   logic signed [SINE_WIDTH:0] w_s;
   logic                       w_accept;
   logic                       w_below;
   logic                       w_above;
   logic                       w_cross;
   logic [COUNT_WIDTH-1:0]     w_count_inc;
   logic [AVG_LOG2:0]          w_ncross_inc;
   logic                       w_complete;
   logic                       w_timeout;

   assign w_s          = $signed({1'b0, sample}) - MID_S;
   assign w_accept     = enable && sample_valid;
   assign w_below      = w_s < NEG_HYST_S;
   assign w_above      = w_s > HYST_S;
   assign w_cross      = r_armed && w_above;
   assign w_count_inc  = r_count + 1'b1;
   assign w_ncross_inc = r_ncross + 1'b1;
   assign w_complete   = (r_state == MEASURE) && w_cross && (w_ncross_inc == NWIN_C);
   assign w_timeout    = (w_count_inc == TIMEOUT_C);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= SEEK;
         r_armed        <= 1'b0;
         r_count        <= '0;
         r_ncross       <= '0;
         r_period_sum   <= '0;
         r_period_valid <= 1'b0;
         r_signal_lost  <= 1'b1;
         r_crossing     <= 1'b0;
      end else begin
         // Strobes are recomputed every cycle so they drop while enable is low.
         r_crossing     <= w_accept && w_cross;
         r_period_valid <= w_accept && w_complete;
         if (w_accept) begin
            if (w_below) begin
               r_armed <= 1'b1;
            end else if (w_cross) begin
               r_armed <= 1'b0;
            end
            case (r_state)
               SEEK: begin
                  if (w_cross) begin
                     r_state  <= MEASURE;
                     r_count  <= '0;
                     r_ncross <= '0;
                  end
               end
               MEASURE: begin
                  // The completing crossing also opens the next window.
                  if (w_complete) begin
                     r_period_sum  <= w_count_inc;
                     r_signal_lost <= 1'b0;
                     r_count       <= '0;
                     r_ncross      <= '0;
                  end else if (w_timeout) begin
                     r_state       <= SEEK;
                     r_signal_lost <= 1'b1;
                     r_count       <= '0;
                     r_ncross      <= '0;
                  end else begin
                     r_count <= w_count_inc;
                     if (w_cross) begin
                        r_ncross <= w_ncross_inc;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign period_sum   = r_period_sum;
   assign period_valid = r_period_valid;
   assign signal_lost  = r_signal_lost;
   assign crossing     = r_crossing;

endmodule

// File: tb/tb_fm_period_demod.sv
// Directed bench for fm_period_demod: square-wave lock, sparse valids, noise in the
// hysteresis band, timeout and relock, mid-window reset, and enable freeze.
module tb_fm_period_demod;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        sample_valid;
   logic [6:0]  sample;
   logic [15:0] period_sum;
   logic        period_valid;
   logic        signal_lost;
   logic        crossing;

   int total;
   int passed;
   int idx;
   int ph;
   int n_xing;
   int first_xing;
   int pv_q[$];

   fm_period_demod #(
      .SINE_WIDTH(7), .HYST(4), .AVG_LOG2(4), .COUNT_WIDTH(16), .TIMEOUT(4096)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .sample(sample), .period_sum(period_sum), .period_valid(period_valid),
      .signal_lost(signal_lost), .crossing(crossing)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_stats();
      idx = 0;
      n_xing = 0;
      first_xing = -1;
      pv_q.delete();
      ph = 0;
   endtask

   task automatic step(input logic en, input logic v, input logic [6:0] smp);
      enable = en;
      sample_valid = v;
      sample = smp;
      @(posedge clk);
      #1;
      if (crossing === 1'b1) begin
         n_xing++;
         if (first_xing < 0) first_xing = idx;
      end
      if (period_valid === 1'b1) pv_q.push_back(idx);
      idx++;
   endtask

   // Wave advances only on accepted samples: 0x70 x4 then 0x10 x4.
   task automatic wave_step(input logic en, input logic v);
      logic [6:0] smp;
      smp = (ph < 4) ? 7'h70 : 7'h10;
      step(en, v, smp);
      if (en && v) ph = (ph + 1) % 8;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b1, 1'b0, 7'h40);
      reset = 1'b0;
   endtask

   function automatic int pv_at(input int k);
      return (pv_q.size() > k) ? pv_q[k] : -1;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step(1'b1, 1'b1, 7'h70);
      step(1'b1, 1'b1, 7'h10);
      reset = 1'b0;
      total++; if (period_sum !== 16'd0) $display("FAIL reset_sum: got %0d expected 0", period_sum); else passed++;
      total++; if (period_valid !== 1'b0) $display("FAIL reset_pv: got %b expected 0", period_valid); else passed++;
      total++; if (signal_lost !== 1'b1) $display("FAIL reset_lost: got %b expected 1", signal_lost); else passed++;
      total++; if (crossing !== 1'b0) $display("FAIL reset_xing: got %b expected 0", crossing); else passed++;
      $display("test_reset done: sum=%0d pv=%b lost=%b xing=%b", period_sum, period_valid, signal_lost, crossing);
   endtask

   task automatic test_square();
      do_reset();
      clear_stats();
      for (int i = 0; i < 136; i++) wave_step(1'b1, 1'b1);
      total++; if (first_xing !== 8) $display("FAIL sq_first_xing: got %0d expected 8", first_xing); else passed++;
      total++; if (signal_lost !== 1'b1) $display("FAIL sq_lost_before: got %b expected 1", signal_lost); else passed++;
      total++; if (pv_q.size() !== 0) $display("FAIL sq_early_pv: got %0d strobes expected 0", pv_q.size()); else passed++;
      wave_step(1'b1, 1'b1);
      total++; if (pv_at(0) !== 136) $display("FAIL sq_pv1_idx: got %0d expected 136", pv_at(0)); else passed++;
      total++; if (period_sum !== 16'd128) $display("FAIL sq_sum1: got %0d expected 128", period_sum); else passed++;
      total++; if (signal_lost !== 1'b0) $display("FAIL sq_lost_after: got %b expected 0", signal_lost); else passed++;
      for (int i = 0; i < 128; i++) wave_step(1'b1, 1'b1);
      total++; if (pv_at(1) !== 264 || pv_q.size() !== 2) $display("FAIL sq_pv2: got idx %0d count %0d expected 264 count 2", pv_at(1), pv_q.size()); else passed++;
      total++; if (period_sum !== 16'd128) $display("FAIL sq_sum2: got %0d expected 128", period_sum); else passed++;
      total++; if (n_xing !== 33) $display("FAIL sq_xings: got %0d expected 33", n_xing); else passed++;
      $display("test_square done: strobes=%0d crossings=%0d sum=%0d", pv_q.size(), n_xing, period_sum);
   endtask

   task automatic test_half_valid();
      do_reset();
      clear_stats();
      for (int i = 0; i < 530; i++) wave_step(1'b1, (i % 2) == 0);
      total++; if (pv_at(0) !== 272) $display("FAIL half_pv1: got %0d expected 272", pv_at(0)); else passed++;
      total++; if (pv_at(1) !== 528 || pv_q.size() !== 2) $display("FAIL half_pv2: got idx %0d count %0d expected 528 count 2", pv_at(1), pv_q.size()); else passed++;
      total++; if (period_sum !== 16'd128) $display("FAIL half_sum: got %0d expected 128", period_sum); else passed++;
      $display("test_half_valid done: strobes=%0d sum=%0d", pv_q.size(), period_sum);
   endtask

   task automatic test_noise();
      do_reset();
      clear_stats();
      for (int i = 0; i < 300; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 7'h42 : 7'h3E);
      total++; if (n_xing !== 0) $display("FAIL noise_xing: got %0d expected 0", n_xing); else passed++;
      total++; if (pv_q.size() !== 0) $display("FAIL noise_pv: got %0d expected 0", pv_q.size()); else passed++;
      total++; if (signal_lost !== 1'b1) $display("FAIL noise_lost: got %b expected 1", signal_lost); else passed++;
      total++; if (period_sum !== 16'd0) $display("FAIL noise_sum: got %0d expected 0", period_sum); else passed++;
      $display("test_noise done: crossings=%0d strobes=%0d lost=%b", n_xing, pv_q.size(), signal_lost);
   endtask

   task automatic test_timeout();
      int base;
      do_reset();
      clear_stats();
      for (int i = 0; i < 137; i++) wave_step(1'b1, 1'b1);
      for (int i = 0; i < 4095; i++) step(1'b1, 1'b1, 7'h40);
      total++; if (signal_lost !== 1'b0) $display("FAIL to_lost_early: got %b expected 0", signal_lost); else passed++;
      step(1'b1, 1'b1, 7'h40);
      total++; if (signal_lost !== 1'b1) $display("FAIL to_lost: got %b expected 1", signal_lost); else passed++;
      total++; if (period_sum !== 16'd128) $display("FAIL to_sum_hold: got %0d expected 128", period_sum); else passed++;
      total++; if (pv_q.size() !== 1) $display("FAIL to_pv_count: got %0d expected 1", pv_q.size()); else passed++;
      base = idx;
      ph = 0;
      for (int i = 0; i < 137; i++) wave_step(1'b1, 1'b1);
      total++; if (pv_at(1) !== base + 136 || pv_q.size() !== 2) $display("FAIL to_relock_idx: got %0d count %0d expected %0d count 2", pv_at(1), pv_q.size(), base + 136); else passed++;
      total++; if (period_sum !== 16'd128 || signal_lost !== 1'b0) $display("FAIL to_relock: got sum %0d lost %b expected 128 0", period_sum, signal_lost); else passed++;
      $display("test_timeout done: strobes=%0d sum=%0d lost=%b", pv_q.size(), period_sum, signal_lost);
   endtask

   task automatic test_reset_mid();
      do_reset();
      clear_stats();
      for (int i = 0; i < 177; i++) wave_step(1'b1, 1'b1);
      do_reset();
      total++; if (period_sum !== 16'd0) $display("FAIL mid_sum: got %0d expected 0", period_sum); else passed++;
      total++; if (signal_lost !== 1'b1) $display("FAIL mid_lost: got %b expected 1", signal_lost); else passed++;
      total++; if (period_valid !== 1'b0 || crossing !== 1'b0) $display("FAIL mid_strobes: got pv %b xing %b expected 0 0", period_valid, crossing); else passed++;
      clear_stats();
      for (int i = 0; i < 137; i++) wave_step(1'b1, 1'b1);
      total++; if (pv_at(0) !== 136 || pv_q.size() !== 1) $display("FAIL mid_pv: got idx %0d count %0d expected 136 count 1", pv_at(0), pv_q.size()); else passed++;
      total++; if (period_sum !== 16'd128) $display("FAIL mid_sum_after: got %0d expected 128", period_sum); else passed++;
      $display("test_reset_mid done: strobes=%0d sum=%0d", pv_q.size(), period_sum);
   endtask

   task automatic test_enable();
      int xing_before;
      do_reset();
      clear_stats();
      for (int i = 0; i < 157; i++) wave_step(1'b1, 1'b1);
      xing_before = n_xing;
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 7'h70 : 7'h10);
      total++; if (n_xing !== xing_before) $display("FAIL en_xing: got %0d expected %0d", n_xing, xing_before); else passed++;
      total++; if (pv_q.size() !== 1) $display("FAIL en_pv_frozen: got %0d expected 1", pv_q.size()); else passed++;
      for (int i = 0; i < 108; i++) wave_step(1'b1, 1'b1);
      total++; if (pv_at(1) !== 314 || pv_q.size() !== 2) $display("FAIL en_pv_idx: got %0d count %0d expected 314 count 2", pv_at(1), pv_q.size()); else passed++;
      total++; if (period_sum !== 16'd128) $display("FAIL en_sum: got %0d expected 128", period_sum); else passed++;
      $display("test_enable done: strobes=%0d sum=%0d", pv_q.size(), period_sum);
   endtask

   initial begin
      total = 0;
      passed = 0;
      reset = 1'b1;
      enable = 1'b0;
      sample_valid = 1'b0;
      sample = 7'h40;
      clear_stats();
      test_reset();
      test_square();
      test_half_valid();
      test_noise();
      test_timeout();
      test_reset_mid();
      test_enable();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fm_period_demod.md
Name: fm_period_demod

Overview:
- Receive-side counterpart of the FM sine DAC path.
- Consumes unsigned offset-binary sine samples from the ADC front end.
- Detects rising mid-scale crossings with hysteresis and counts accepted samples across 2**AVG_LOG2 consecutive carrier periods.
- Emits the period sum as a strobed measurement for the downstream period-to-distance LUT. Also flags loss of signal.

Parameters:
SINE_WIDTH, 7, bit width of input sample (unsigned, mid-scale = 2**(SINE_WIDTH-1))
HYST, 4, hysteresis threshold in LSBs around mid-scale
AVG_LOG2, 4, log2 of carrier periods per measurement window
COUNT_WIDTH, 16, width of sample counter and period_sum
TIMEOUT, 4096, accepted samples without window completion before signal loss; must be < 2**COUNT_WIDTH

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
enable  input  1  global clock enable; low freezes all state
sample_valid  input  1  sample qualifier
sample  input  SINE_WIDTH  ADC sample, unsigned offset-binary
period_sum  output  COUNT_WIDTH  accepted-sample count over last completed window
period_valid  output  1  one-cycle strobe; period_sum updated
signal_lost  output  1  high when no valid measurement since reset/timeout
crossing  output  1  one-cycle strobe per detected rising crossing

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on posedge clk.
- Accepted sample: enable && sample_valid. No state changes on any other cycle.
- s = sample - 2**(SINE_WIDTH-1), signed, SINE_WIDTH+1 bits.
- Hysteresis detector:
  - armed <= 1 when s < -HYST (strict).
  - Rising crossing when armed && s > +HYST (strict). armed <= 0 on that crossing.
  - Samples with |s| <= HYST leave armed unchanged.
- crossing is registered. It pulses the cycle after the accepted crossing sample, in any state.
- FSM states SEEK and MEASURE:
  - SEEK: count = 0, ncross = 0. On first crossing -> MEASURE, count <= 0. The starting crossing sample is not counted.
  - MEASURE: each accepted sample does count <= count+1.
  - On each crossing, ncross <= ncross+1.
  - When a crossing brings ncross to 2**AVG_LOG2:
    - period_sum <= count+1; period_valid pulses next cycle; signal_lost <= 0.
    - count <= 0, ncross <= 0, stay in MEASURE. The ending crossing starts the next window, so windows are back-to-back.
  - Timeout: if count+1 == TIMEOUT on an accepted sample with no window completion -> SEEK, signal_lost <= 1, count and ncross cleared, period_sum held.
  - Completion and timeout on the same sample: completion wins, no loss.
- Latency: period_valid is exactly 1 cycle after the accepted sample that completes the window.
- Width rule: count never exceeds TIMEOUT, so no overflow or saturation logic is needed.
- enable low: all registers hold; period_valid and crossing forced 0.
- Reset values (also apply on reset mid-window, which discards the partial window):
  - state SEEK, armed 0, count 0, ncross 0
  - period_sum 0, period_valid 0, crossing 0, signal_lost 1
- Disallowed parameter value: HYST >= 2**(SINE_WIDTH-1)-1. It makes crossings impossible; flag it with an elaboration check.

Test Plan:
- Square wave, 8-sample period (0x70 x4, 0x10 x4), sample_valid=1 always -> crossing every 8 samples; first period_valid 128 samples after first crossing with period_sum=128; repeats every 128 cycles; signal_lost 1->0 at first strobe.
- Same stimulus with sample_valid high every other cycle -> period_sum=128, period_valid every 256 cycles.
- Input alternating 0x42/0x3E (|s|=2 <= HYST) from reset -> no crossing, no period_valid, signal_lost stays 1.
- Lock with 8-sample wave, then hold 0x40 -> signal_lost=1 exactly 4096 accepted samples after the last window start; FSM in SEEK; period_sum holds 128; wave resumes -> relock, next strobe period_sum=128.
- Reset asserted one cycle mid-window -> all outputs at reset values next cycle; the first period_sum after release counts only post-reset samples (128).
- enable low for 50 cycles mid-window while the wave continues -> window stretches, but period_sum still 128; no strobes while enable is low.
